// File: rtl/spi_controller.sv
// SPI mode-0 bus master: byte-stream valid/ready in, one-cycle rx strobe out.
// tx_last closes the frame; chained bytes keep csn low through a WAIT state.
module spi_controller #(
  parameter int TICKS_PER_HALF_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       spi_sck,
  output logic       spi_csn,
  output logic       spi_sdo,
  input  logic       spi_sdi
);

  localparam int CW = $clog2(TICKS_PER_HALF_BIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] tx_byte, tx_byte_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic [7:0] rx_data_n;
  logic       last, last_n;
  logic       rx_valid_n, sck_n, csn_n, sdo_n, tx_ready_n;
  logic       half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_byte  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      last     <= 1'b0;
      rx_valid <= 1'b0;
      spi_sck  <= 1'b0;
      spi_csn  <= 1'b1;
      spi_sdo  <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      tx_byte  <= tx_byte_n;
      rx_shift <= rx_shift_n;
      rx_data  <= rx_data_n;
      last     <= last_n;
      rx_valid <= rx_valid_n;
      spi_sck  <= sck_n;
      spi_csn  <= csn_n;
      spi_sdo  <= sdo_n;
      tx_ready <= tx_ready_n;
    end
  end

  // sck only toggles in SHIFT on a counter wrap, so it cannot glitch elsewhere
  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    bit_idx_n  = bit_idx;
    tx_byte_n  = tx_byte;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data;
    last_n     = last;
    rx_valid_n = 1'b0;
    sck_n      = 1'b0;
    csn_n      = spi_csn;
    sdo_n      = spi_sdo;
    tx_ready_n = tx_ready;
    half       = (cnt == CNT_LAST);

    case (state)
      S_IDLE, S_WAIT: begin
        if (tx_valid && tx_ready) begin
          tx_byte_n  = tx_data;
          last_n     = tx_last;
          csn_n      = 1'b0;
          sdo_n      = tx_data[7];
          bit_idx_n  = 3'd7;
          tx_ready_n = 1'b0;
          state_n    = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_n = half ? '0 : cnt + CW'(1);
        if (half) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_n = half ? '0 : cnt + CW'(1);
        sck_n = spi_sck;
        if (half && !spi_sck) begin
          sck_n      = 1'b1;
          rx_shift_n = {rx_shift[6:0], spi_sdi};
        end else if (half) begin
          sck_n = 1'b0;
          if (bit_idx != 3'd0) begin
            bit_idx_n = bit_idx - 3'd1;
            sdo_n     = tx_byte[bit_idx - 3'd1];
          end else begin
            rx_data_n  = rx_shift;
            rx_valid_n = 1'b1;
            if (last) begin
              state_n = S_HOLD;
            end else begin
              state_n    = S_WAIT;
              tx_ready_n = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        cnt_n = half ? '0 : cnt + CW'(1);
        if (half) begin
          csn_n   = 1'b1;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        cnt_n = half ? '0 : cnt + CW'(1);
        if (half) begin
          state_n    = S_IDLE;
          tx_ready_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: two lanes (T=2 and T=1) share one clock,
// each with its own stimulus, peripheral model and monitor.
module tb_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=absent required=present", name);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int T = (g == 0) ? 2 : 1;

    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, sck, csn, sdo, sdi;
    logic       p_sdi = 1'b0;
    logic       loop_en = 1'b1;
    logic       done_l = 1'b0;

    spi_controller #(.TICKS_PER_HALF_BIT(T)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .spi_sck(sck), .spi_csn(csn), .spi_sdo(sdo),
      .spi_sdi(sdi)
    );

    assign sdi = loop_en ? sdo : p_sdi;

    // Reference expectations: bytes out MSB first, bytes in, and per-frame shape
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] p_q[$];
    int         exp_nb_q[$];
    int         exp_len_q[$];
    int         frame_bytes = 0;
    int         frame_len = 0;

    // Peripheral model: presents the front response byte, advancing on sck falls
    int   p_bit = 0;
    logic p_sck_prev = 1'b0;
    always @(negedge clk) begin
      logic [7:0] cur;
      if (csn !== 1'b0) p_bit = 0;
      else if (p_sck_prev && !sck) begin
        p_bit++;
        if (p_bit == 8) begin
          p_bit = 0;
          if (p_q.size() != 0) void'(p_q.pop_front());
        end
      end
      p_sck_prev = sck;
      cur = (p_q.size() != 0) ? p_q[0] : 8'h00;
      p_sdi = cur[7 - p_bit];
    end

    int         low_len = 0, high_len = 0, last_high_len = 0;
    int         frame_rx = 0, bit_cnt = 0, since_rise = 0;
    logic [7:0] cap = 8'h00;
    logic       m_csn_prev = 1'b1, m_sck_prev = 1'b0, m_rxv_prev = 1'b0;
    always @(negedge clk) begin
      if (rst) begin
        low_len = 0; high_len = 0; frame_rx = 0; bit_cnt = 0; cap = 8'h00;
        m_csn_prev = 1'b1; m_sck_prev = 1'b0; m_rxv_prev = 1'b0;
      end else begin
        if (rx_valid) begin
          check_output($sformatf("T%0d rx_valid one cycle", T), m_rxv_prev, 0);
          if (exp_rx_q.size() == 0) report_fail($sformatf("T%0d expected rx byte", T));
          else check_output($sformatf("T%0d rx_data", T), rx_data, exp_rx_q.pop_front());
          frame_rx++;
        end
        m_rxv_prev = rx_valid;
        if (!m_sck_prev && sck) begin
          if (bit_cnt != 0) check_output($sformatf("T%0d sck period", T), since_rise, 2 * T);
          cap = {cap[6:0], sdo};
          bit_cnt++;
          since_rise = 0;
          if (bit_cnt == 8) begin
            bit_cnt = 0;
            if (exp_tx_q.size() == 0) report_fail($sformatf("T%0d expected sdo byte", T));
            else check_output($sformatf("T%0d sdo byte", T), cap, exp_tx_q.pop_front());
          end
        end
        since_rise++;
        m_sck_prev = sck;
        if (!csn) begin
          if (m_csn_prev) last_high_len = high_len;
          low_len++;
          high_len = 0;
        end else begin
          if (!m_csn_prev) begin
            check_output($sformatf("T%0d sck idle at csn rise", T), sck, 0);
            if (exp_len_q.size() == 0) report_fail($sformatf("T%0d expected frame", T));
            else begin
              check_output($sformatf("T%0d csn low cycles", T), low_len, exp_len_q.pop_front());
              check_output($sformatf("T%0d bytes in frame", T), frame_rx, exp_nb_q.pop_front());
            end
            low_len = 0;
            frame_rx = 0;
          end
          high_len++;
        end
        m_csn_prev = csn;
      end
    end

    task automatic wait_ready();
      int guard = 0;
      while (tx_ready !== 1'b1 && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) report_fail($sformatf("T%0d tx_ready timeout", T));
    endtask

    task automatic wait_idle();
      int guard = 0;
      while (!(csn === 1'b1 && tx_ready === 1'b1) && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) report_fail($sformatf("T%0d idle timeout", T));
    endtask

    // Junk is driven on tx_data while tx_valid waits for tx_ready; it must never appear on sdo
    task automatic apply_stimulus(input logic [7:0] data, input logic last,
                                  input logic [7:0] resp, input int idle);
      int guard = 0;
      if (idle > 0) begin
        wait_ready();
        repeat (idle) begin
          @(negedge clk);
          if (frame_bytes > 0) begin
            check_output($sformatf("T%0d stall csn", T), csn, 0);
            check_output($sformatf("T%0d stall sck", T), sck, 0);
            check_output($sformatf("T%0d stall tx_ready", T), tx_ready, 1);
          end
        end
      end else begin
        @(negedge clk);
      end
      tx_valid = 1'b1;
      tx_last  = last;
      while (tx_ready !== 1'b1 && guard < 2000) begin
        tx_data = 8'($urandom);
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) report_fail($sformatf("T%0d accept timeout", T));
      tx_data = data;
      exp_tx_q.push_back(data);
      exp_rx_q.push_back(loop_en ? data : resp);
      if (!loop_en) p_q.push_back(resp);
      frame_len += (frame_bytes == 0) ? 18 * T : 17 * T + idle + 1;
      frame_bytes++;
      if (last) begin
        exp_nb_q.push_back(frame_bytes);
        exp_len_q.push_back(frame_len);
        frame_bytes = 0;
        frame_len = 0;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      tx_last  = 1'($urandom);
    endtask

    initial begin
      int rises, guard, nb;
      logic prev;
      repeat (3) @(negedge clk);
      check_output($sformatf("T%0d reset csn", T), csn, 1);
      check_output($sformatf("T%0d reset sck", T), sck, 0);
      check_output($sformatf("T%0d reset sdo", T), sdo, 0);
      check_output($sformatf("T%0d reset tx_ready", T), tx_ready, 1);
      check_output($sformatf("T%0d reset rx_valid", T), rx_valid, 0);
      check_output($sformatf("T%0d reset rx_data", T), rx_data, 0);
      rst = 1'b0;

      loop_en = 1'b1;
      apply_stimulus(8'hA5, 1'b1, 8'h00, 0);
      wait_idle();

      loop_en = 1'b0;
      apply_stimulus(8'hFF, 1'b0, 8'h3C, 0);
      apply_stimulus(8'h00, 1'b1, 8'($urandom), 0);
      wait_idle();

      loop_en = 1'b1;
      apply_stimulus(8'h81, 1'b0, 8'h00, 0);
      apply_stimulus(8'h7E, 1'b1, 8'h00, 20);
      wait_idle();

      apply_stimulus(8'hC3, 1'b1, 8'h00, 0);
      apply_stimulus(8'($urandom), 1'b1, 8'h00, 0);
      repeat (2) @(negedge clk);
      check_output($sformatf("T%0d deselect cycles", T), last_high_len, T + 1);
      wait_idle();

      apply_stimulus(8'hE7, 1'b1, 8'h00, 0);
      rises = 0;
      guard = 0;
      prev = sck;
      while (rises < 4 && guard < 1000) begin
        @(posedge clk);
        #1;
        if (sck && !prev) rises++;
        prev = sck;
        guard++;
      end
      if (guard >= 1000) report_fail($sformatf("T%0d sck rise timeout", T));
      rst = 1'b1;
      #1;
      check_output($sformatf("T%0d abort csn", T), csn, 1);
      check_output($sformatf("T%0d abort sck", T), sck, 0);
      check_output($sformatf("T%0d abort sdo", T), sdo, 0);
      exp_tx_q.delete();
      exp_rx_q.delete();
      exp_nb_q.delete();
      exp_len_q.delete();
      p_q.delete();
      frame_bytes = 0;
      frame_len = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      apply_stimulus(8'h5A, 1'b1, 8'h00, 0);
      wait_idle();

      repeat (12) begin
        loop_en = 1'($urandom);
        nb = $urandom_range(1, 3);
        for (int i = 0; i < nb; i++)
          apply_stimulus(8'($urandom), (i == nb - 1), 8'($urandom),
                         ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0);
        wait_idle();
      end

      repeat (5) @(negedge clk);
      check_output($sformatf("T%0d rx bytes outstanding", T), exp_rx_q.size(), 0);
      check_output($sformatf("T%0d sdo bytes outstanding", T), exp_tx_q.size(), 0);
      check_output($sformatf("T%0d frames outstanding", T), exp_len_q.size(), 0);
      done_l = 1'b1;
    end
  end

  initial begin
    int guard = 0;
    while (!(lane[0].done_l && lane[1].done_l) && guard < 90000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 90000) report_fail("bench completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
